// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB request arbiter.
// ADDR_WIDTH / DATA_WIDTH come from apb_arch.svh when present; defaults are supplied otherwise.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_arb_pkg;

  localparam int unsigned ADDR_W = `ADDR_WIDTH;
  localparam int unsigned DATA_W = `DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Bits needed to encode a requester index (at least one).
  function automatic int unsigned gnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
import apb_arb_pkg::*;

module apb_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GNT_W   = gnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot_c,
  output logic [GNT_W-1:0]   idx_c,
  output logic               any_c
);

  logic [GNT_W:0] k;

  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    any_c    = 1'b0;
    k        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (GNT_W+1)'(ptr) + (GNT_W+1)'(i);
      if (k >= (GNT_W+1)'(NUM_REQ)) k = k - (GNT_W+1)'(NUM_REQ);
      if (!any_c && req[k[GNT_W-1:0]]) begin
        any_c                 = 1'b1;
        onehot_c[k[GNT_W-1:0]] = 1'b1;
        idx_c                 = k[GNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing the APB master's CPU-side channel between NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining APB_ARB_TIMEOUT_EN.
import apb_arb_pkg::*;

module apb_req_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  req_wr,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*`DATA_WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                  done,
  output logic [`DATA_WIDTH-1:0]              rsp_rdata,
  output logic                                rsp_err,
  output logic                                start,
  output logic                                wr,
  output logic [`ADDR_WIDTH-1:0]              address,
  output logic [`DATA_WIDTH-1:0]              data_in,
  input  logic                                apb_sel,
  input  logic                                apb_enable,
  input  logic                                apb_ready,
  input  logic                                apb_slverr,
  input  logic [`DATA_WIDTH-1:0]              apb_rdata,
  output logic [gnt_width(NUM_REQ)-1:0]       gnt_id,
  output logic                                busy
);

  localparam int unsigned GNT_W = gnt_width(NUM_REQ);
  localparam int unsigned AW    = `ADDR_WIDTH;
  localparam int unsigned DW    = `DATA_WIDTH;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_req_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  arb_state_t         state, state_nxt;
  logic [GNT_W-1:0]   ptr;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] pick_oh_c;
  logic [GNT_W-1:0]   pick_idx_c;
  logic               pick_any_c;
  logic               cmpl_c;
  logic               tmo_c;
  logic               load_c;
  logic               capture_c;
  logic               start_nxt, busy_nxt;
  logic [NUM_REQ-1:0] done_nxt;

  apb_rr_picker #(.NUM_REQ(NUM_REQ), .GNT_W(GNT_W)) u_picker (
    .req      (req),
    .ptr      (ptr),
    .onehot_c (pick_oh_c),
    .idx_c    (pick_idx_c),
    .any_c    (pick_any_c)
  );

  assign cmpl_c = apb_sel & apb_enable & apb_ready;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts WAIT cycles; held at zero outside WAIT so each WAIT entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
    else                     wait_cnt <= '0;
  end

  assign tmo_c = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any_c) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (cmpl_c || tmo_c) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_c    = (state == IDLE) && pick_any_c;
    capture_c = (state == WAIT) && (cmpl_c || tmo_c);
    start_nxt = (state_nxt == START);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == RESP) ? gnt_oh : '0;
  end

  // Registered outputs and grant/response latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= '0;
      gnt_id    <= '0;
      gnt_oh    <= '0;
      ptr       <= '0;
      wr        <= 1'b0;
      address   <= '0;
      data_in   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      start <= start_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      if (load_c) begin
        gnt_id  <= pick_idx_c;
        gnt_oh  <= pick_oh_c;
        wr      <= req_wr[pick_idx_c];
        address <= req_addr[pick_idx_c*AW +: AW];
        data_in <= req_wdata[pick_idx_c*DW +: DW];
      end
      // A completion wins over a coincident timeout.
      if (capture_c) begin
        rsp_rdata <= (cmpl_c && !wr) ? apb_rdata : '0;
        rsp_err   <= cmpl_c ? apb_slverr : 1'b1;
      end
      if (state == RESP) begin
        ptr <= (gnt_id == GNT_W'(NUM_REQ - 1)) ? '0 : gnt_id + GNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8).
// Honours APB_ARB_TIMEOUT_EN in the timeout scenario.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned DW = `DATA_WIDTH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, start, wr, busy;
  logic [AW-1:0]   address;
  logic [DW-1:0]   data_in;
  logic            apb_sel, apb_enable, apb_ready, apb_slverr;
  logic [DW-1:0]   apb_rdata;
  logic [1:0]      gnt_id;

  int checks = 0;
  int errors = 0;

  apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .start(start), .wr(wr), .address(address), .data_in(data_in),
    .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_ready(apb_ready),
    .apb_slverr(apb_slverr), .apb_rdata(apb_rdata), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_complete(input logic [DW-1:0] rdata, input logic err);
    apb_sel = 1'b1; apb_enable = 1'b1; apb_ready = 1'b1;
    apb_rdata = rdata; apb_slverr = err;
  endtask

  task automatic bus_idle();
    apb_sel = 1'b0; apb_enable = 1'b0; apb_ready = 1'b0;
    apb_rdata = '0; apb_slverr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    bus_idle();
    step(); step();
    checks++;
    if ({start, wr, busy, rsp_err, done, gnt_id} !== '0 || address !== '0 || data_in !== '0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_values: start=%b wr=%b busy=%b err=%b done=%b gnt=%0d addr=%h din=%h rdata=%h, required all 0",
               start, wr, busy, rsp_err, done, gnt_id, address, data_in, rsp_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    req = 4'b0010; req_wr = 4'b0010;
    req_addr[1*AW +: AW] = 32'h10; req_wdata[1*DW +: DW] = 32'hA5A5;
    step();
    checks++;
    if (start !== 1'b1 || gnt_id !== 2'd1 || address !== 32'h10 || data_in !== 32'hA5A5 || wr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_launch: start=%b gnt=%0d addr=%h din=%h wr=%b busy=%b, required 1 1 10 a5a5 1 1",
               start, gnt_id, address, data_in, wr, busy);
    end
    req = '0; req_addr[1*AW +: AW] = 32'hFF; req_wdata[1*DW +: DW] = 32'h0;
    step();
    checks++;
    if (start !== 1'b0 || address !== 32'h10 || data_in !== 32'hA5A5) begin
      errors++;
      $display("FAIL write_latched: start=%b addr=%h din=%h, required 0 10 a5a5", start, address, data_in);
    end
    bus_complete(32'hDEAD, 1'b0);
    step();
    bus_idle();
    checks++;
    if (done !== 4'b0010 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL write_done: done=%b err=%b rdata=%h, required 0010 0 0", done, rsp_err, rsp_rdata);
    end
    step();
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: done=%b busy=%b, required 0000 0", done, busy);
    end
  endtask

  task automatic test_read();
    req = 4'b0100; req_wr = 4'b0000; req_addr[2*AW +: AW] = 32'h20;
    step();
    checks++;
    if (start !== 1'b1 || gnt_id !== 2'd2 || address !== 32'h20 || wr !== 1'b0) begin
      errors++;
      $display("FAIL read_launch: start=%b gnt=%0d addr=%h wr=%b, required 1 2 20 0", start, gnt_id, address, wr);
    end
    req = '0;
    step(); step();
    checks++;
    if (done !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_wait: done=%b busy=%b, required 0000 1", done, busy);
    end
    bus_complete(32'h1234, 1'b0);
    step();
    bus_idle();
    checks++;
    if (done !== 4'b0100 || rsp_rdata !== 32'h1234 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL read_done: done=%b rdata=%h err=%b, required 0100 1234 0", done, rsp_rdata, rsp_err);
    end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_order [4];
    exp_order[0] = 2'd0; exp_order[1] = 2'd3; exp_order[2] = 2'd0; exp_order[3] = 2'd3;
    test_reset();
    req = 4'b1001; req_wr = '0;
    for (int t = 0; t < 4; t++) begin
      step();
      checks++;
      if (start !== 1'b1 || gnt_id !== exp_order[t]) begin
        errors++;
        $display("FAIL contention_grant%0d: start=%b gnt=%0d, required 1 %0d", t, start, gnt_id, exp_order[t]);
      end
      step();
      bus_complete(32'h0, 1'b0);
      step();
      bus_idle();
      checks++;
      if (done !== (4'b0001 << exp_order[t])) begin
        errors++;
        $display("FAIL contention_done%0d: done=%b, required %b", t, done, 4'b0001 << exp_order[t]);
      end
      step();
    end
    req = '0;
    step();
  endtask

  task automatic test_slverr();
    req = 4'b0010; req_wr = '0;
    step();
    req = '0;
    step();
    bus_complete(32'h55, 1'b1);
    step();
    bus_idle();
    checks++;
    if (done !== 4'b0010 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL slverr_done: done=%b err=%b, required 0010 1", done, rsp_err);
    end
    step();
    req = 4'b0110;
    step();
    checks++;
    if (start !== 1'b1 || gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL slverr_ptr_advance: start=%b gnt=%0d, required 1 2", start, gnt_id);
    end
    req = '0;
    step();
    bus_complete(32'h0, 1'b0);
    step();
    bus_idle();
    checks++;
    if (done !== 4'b0100 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL slverr_clear: done=%b err=%b, required 0100 0", done, rsp_err);
    end
    step();
  endtask

  task automatic test_timeout();
    req = 4'b0001; req_wr = 4'b0001;
    step();
    req = '0;
    step();
`ifdef APB_ARB_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      step();
      checks++;
      if (done !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early%0d: done=%b busy=%b, required 0000 1", c, done, busy);
      end
    end
    step();
    checks++;
    if (done !== 4'b0001 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_resp: done=%b err=%b rdata=%h, required 0001 1 0", done, rsp_err, rsp_rdata);
    end
    step();
`else
    for (int c = 0; c < 20; c++) step();
    checks++;
    if (done !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout_hold: done=%b busy=%b, required 0000 1", done, busy);
    end
    bus_complete(32'h0, 1'b0);
    step();
    bus_idle();
    checks++;
    if (done !== 4'b0001 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_done: done=%b err=%b, required 0001 0", done, rsp_err);
    end
    step();
`endif
    checks++;
    if (busy !== 1'b0 || done !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b done=%b, required 0 0000", busy, done);
    end
  endtask

  task automatic test_reset_in_wait();
    req = 4'b0100; req_wr = '0; req_addr[2*AW +: AW] = 32'h20;
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start, wr, busy, rsp_err, done, gnt_id} !== '0 || address !== '0 || data_in !== '0) begin
      errors++;
      $display("FAIL reset_in_wait: start=%b wr=%b busy=%b err=%b done=%b gnt=%0d addr=%h din=%h, required all 0",
               start, wr, busy, rsp_err, done, gnt_id, address, data_in);
    end
    step();
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done=%b busy=%b, required 0000 0", done, busy);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (start !== 1'b1 || gnt_id !== 2'd2 || address !== 32'h20) begin
      errors++;
      $display("FAIL reset_regrant: start=%b gnt=%0d addr=%h, required 1 2 20", start, gnt_id, address);
    end
    req = '0;
    step();
    bus_complete(32'h77, 1'b0);
    step();
    bus_idle();
    checks++;
    if (done !== 4'b0100 || rsp_rdata !== 32'h77) begin
      errors++;
      $display("FAIL reset_regrant_done: done=%b rdata=%h, required 0100 77", done, rsp_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_slverr();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
